// File: rtl/fpu_mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fpu_mult_arbiter
// Description : Two-requester round-robin arbiter that fronts one shared,
//               fixed-latency floating-point multiplier.
// Revision    : 1.0
// ============================================================================
module fpu_mult_arbiter #(
    parameter int MUL_LATENCY = 1,
    parameter int W           = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    output logic         req1_ready,
    output logic         resp0_valid,
    input  logic         resp0_ready,
    output logic         resp1_valid,
    input  logic         resp1_ready,
    output logic [W-1:0] resp_result,
    output logic         resp_overflow,
    output logic [W-1:0] mul_a,
    output logic [W-1:0] mul_b,
    input  logic [W-1:0] mul_result,
    input  logic         mul_overflow,
    output logic         busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [3:0] c_lat = 4'(MUL_LATENCY);

    state_t       r_state;
    logic [3:0]   r_cnt;
    logic         r_last_gnt;
    logic         r_gnt;
    logic [W-1:0] r_op_a;
    logic [W-1:0] r_op_b;
    logic [W-1:0] r_result;
    logic         r_ovf;
    logic         r_resp0_valid;
    logic         r_resp1_valid;
    logic         r_busy;

    logic w_sel1;
    logic w_sel0;
    logic w_can_issue;
    logic w_accept;
    logic w_consume;

    // Requester 1 wins a tie only when requester 0 was the last one served.
    assign w_sel1      = req1_valid && (!req0_valid || !r_last_gnt);
    assign w_sel0      = req0_valid && !w_sel1;
    assign w_can_issue = rst_n && (r_state == ST_IDLE);
    assign req0_ready  = w_can_issue && w_sel0;
    assign req1_ready  = w_can_issue && w_sel1;
    assign w_accept    = req0_ready || req1_ready;
    assign w_consume   = (r_state == ST_RESP) && (r_gnt ? resp1_ready : resp0_ready);

    assign mul_a         = r_op_a;
    assign mul_b         = r_op_b;
    assign resp_result   = r_result;
    assign resp_overflow = r_ovf;
    assign resp0_valid   = r_resp0_valid;
    assign resp1_valid   = r_resp1_valid;
    assign busy          = r_busy;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_cnt         <= 4'd0;
            r_last_gnt    <= 1'b1;
            r_gnt         <= 1'b0;
            r_op_a        <= '0;
            r_op_b        <= '0;
            r_result      <= '0;
            r_ovf         <= 1'b0;
            r_resp0_valid <= 1'b0;
            r_resp1_valid <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op_a  <= w_sel1 ? req1_a : req0_a;
                        r_op_b  <= w_sel1 ? req1_b : req0_b;
                        r_gnt   <= w_sel1;
                        r_cnt   <= c_lat;
                        r_state <= ST_BUSY;
                        r_busy  <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_result      <= mul_result;
                        r_ovf         <= mul_overflow;
                        r_resp0_valid <= !r_gnt;
                        r_resp1_valid <= r_gnt;
                        r_state       <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (w_consume) begin
                        r_resp0_valid <= 1'b0;
                        r_resp1_valid <= 1'b0;
                        r_last_gnt    <= r_gnt;
                        r_state       <= ST_IDLE;
                        r_busy        <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fpu_mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpu_mult_arbiter
// Description : Directed self-checking bench for fpu_mult_arbiter at
//               MUL_LATENCY 1 and 4.
// Revision    : 1.0
// ============================================================================
module tb_fpu_mult_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        resp0_valid, resp1_valid, resp0_ready, resp1_ready;
    logic [31:0] resp_result, mul_a, mul_b, mul_result;
    logic        resp_overflow, mul_overflow, busy;

    logic        d4_rst_n;
    logic        d4_req0_valid, d4_req1_valid, d4_req0_ready, d4_req1_ready;
    logic [31:0] d4_req0_a, d4_req0_b, d4_req1_a, d4_req1_b;
    logic        d4_resp0_valid, d4_resp1_valid, d4_resp0_ready, d4_resp1_ready;
    logic [31:0] d4_resp_result, d4_mul_a, d4_mul_b, d4_mul_result;
    logic        d4_resp_overflow, d4_mul_overflow, d4_busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fpu_mult_arbiter #(.MUL_LATENCY(1), .W(32)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
        .resp_result(resp_result), .resp_overflow(resp_overflow),
        .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result), .mul_overflow(mul_overflow),
        .busy(busy)
    );

    fpu_mult_arbiter #(.MUL_LATENCY(4), .W(32)) u_dut4 (
        .clk(clk), .rst_n(d4_rst_n),
        .req0_valid(d4_req0_valid), .req0_a(d4_req0_a), .req0_b(d4_req0_b), .req0_ready(d4_req0_ready),
        .req1_valid(d4_req1_valid), .req1_a(d4_req1_a), .req1_b(d4_req1_b), .req1_ready(d4_req1_ready),
        .resp0_valid(d4_resp0_valid), .resp0_ready(d4_resp0_ready),
        .resp1_valid(d4_resp1_valid), .resp1_ready(d4_resp1_ready),
        .resp_result(d4_resp_result), .resp_overflow(d4_resp_overflow),
        .mul_a(d4_mul_a), .mul_b(d4_mul_b), .mul_result(d4_mul_result), .mul_overflow(d4_mul_overflow),
        .busy(d4_busy)
    );

    // Stand-in multiplier: products of the directed operand pairs, hand-computed.
    function automatic logic [32:0] mul_model(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h40400000, 32'h3FC00000}: return {1'b0, 32'h40900000};
            {32'hC0400000, 32'h3FC00000}: return {1'b0, 32'hC0900000};
            {32'h7F7FFFFF, 32'h40000000}: return {1'b1, 32'h7F800000};
            {32'h40000000, 32'h40400000}: return {1'b0, 32'h40C00000};
            {32'h3F800000, 32'h41200000}: return {1'b0, 32'h41200000};
            default:                      return {1'b0, a ^ b};
        endcase
    endfunction

    always_comb {mul_overflow, mul_result}       = mul_model(mul_a, mul_b);
    always_comb {d4_mul_overflow, d4_mul_result} = mul_model(d4_mul_a, d4_mul_b);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; d4_rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0; resp0_ready = 1'b0; resp1_ready = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        d4_req0_valid = 1'b0; d4_req1_valid = 1'b0; d4_resp0_ready = 1'b0; d4_resp1_ready = 1'b0;
        d4_req0_a = '0; d4_req0_b = '0; d4_req1_a = '0; d4_req1_b = '0;
        step(); step();

        // Reset state; ready held low even with a valid request pending
        req0_valid = 1'b1; req0_a = 32'h40400000; req0_b = 32'h3FC00000;
        #1;
        chk("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_resp_valid", {30'd0, resp1_valid, resp0_valid}, 32'd0);
        chk("rst_mul_a", mul_a, 32'd0);
        chk("rst_result", resp_result, 32'd0);

        // Single request, latency 1
        rst_n = 1'b1;
        #1;
        chk("t1_ready", {30'd0, req1_ready, req0_ready}, 32'd1);
        step();
        req0_valid = 1'b0;
        chk("t1_busy", {31'd0, busy}, 32'd1);
        chk("t1_mul_a", mul_a, 32'h40400000);
        chk("t1_ready_busy", {30'd0, req1_ready, req0_ready}, 32'd0);
        step();
        chk("t1_resp_valid", {30'd0, resp1_valid, resp0_valid}, 32'd1);
        chk("t1_result", resp_result, 32'h40900000);
        chk("t1_ovf", {31'd0, resp_overflow}, 32'd0);
        resp0_ready = 1'b1;
        step();
        resp0_ready = 1'b0;
        chk("t1_consumed", {29'd0, busy, resp1_valid, resp0_valid}, 32'd0);

        // Sign case on requester 1
        req1_valid = 1'b1; req1_a = 32'hC0400000; req1_b = 32'h3FC00000;
        #1;
        chk("t2_ready", {30'd0, req1_ready, req0_ready}, 32'd2);
        step();
        req1_valid = 1'b0;
        step();
        chk("t2_resp_valid", {30'd0, resp1_valid, resp0_valid}, 32'd2);
        chk("t2_result", resp_result, 32'hC0900000);
        chk("t2_ovf", {31'd0, resp_overflow}, 32'd0);
        resp1_ready = 1'b1;
        step();
        resp1_ready = 1'b0;

        // Overflow; the non-granted requester's resp_ready must not consume
        req0_valid = 1'b1; req0_a = 32'h7F7FFFFF; req0_b = 32'h40000000;
        step();
        req0_valid = 1'b0;
        step();
        chk("t3_result", resp_result, 32'h7F800000);
        chk("t3_ovf", {31'd0, resp_overflow}, 32'd1);
        resp1_ready = 1'b1;
        step();
        chk("t3_ignore_resp1_ready", {30'd0, resp1_valid, resp0_valid}, 32'd1);
        chk("t3_hold_result", resp_result, 32'h7F800000);
        resp1_ready = 1'b0; resp0_ready = 1'b1;
        step();
        resp0_ready = 1'b0;
        chk("t3_consumed", {31'd0, busy}, 32'd0);

        // Contention from reset: grants alternate, one issue every 3 cycles
        rst_n = 1'b0;
        req0_valid = 1'b1; req0_a = 32'h40000000; req0_b = 32'h40400000;
        req1_valid = 1'b1; req1_a = 32'h3F800000; req1_b = 32'h41200000;
        resp0_ready = 1'b1; resp1_ready = 1'b1;
        step();
        rst_n = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t4_grant%0d", k), {30'd0, req1_ready, req0_ready}, k[0] ? 32'd2 : 32'd1);
            step();
            chk($sformatf("t4_noissue%0d", k), {30'd0, req1_ready, req0_ready}, 32'd0);
            step();
            chk($sformatf("t4_valid%0d", k), {30'd0, resp1_valid, resp0_valid}, k[0] ? 32'd2 : 32'd1);
            chk($sformatf("t4_result%0d", k), resp_result, k[0] ? 32'h41200000 : 32'h40C00000);
            step();
        end

        // Backpressure on requester 0 with requester 1 waiting
        resp0_ready = 1'b0; resp1_ready = 1'b0;
        #1;
        chk("t5_grant", {30'd0, req1_ready, req0_ready}, 32'd1);
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t5_hold_result%0d", i), resp_result, 32'h40C00000);
            chk($sformatf("t5_hold_state%0d", i), {29'd0, busy, req1_ready, resp0_valid}, 32'h5);
            step();
        end
        resp0_ready = 1'b1;
        step();
        resp0_ready = 1'b0;
        chk("t5_next_grant", {30'd0, req1_ready, req0_ready}, 32'd2);
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();
        chk("t5_resp1", {30'd0, resp1_valid, resp0_valid}, 32'd2);
        chk("t5_result1", resp_result, 32'h41200000);
        resp1_ready = 1'b1;
        step();
        resp1_ready = 1'b0;

        // Latency 4: response exactly four edges after accept
        d4_rst_n = 1'b1;
        d4_req0_valid = 1'b1; d4_req0_a = 32'h40400000; d4_req0_b = 32'h3FC00000;
        #1;
        chk("d4_ready", {30'd0, d4_req1_ready, d4_req0_ready}, 32'd1);
        step();
        d4_req0_valid = 1'b0;
        for (int i = 1; i < 4; i++) begin
            step();
            chk($sformatf("d4_early%0d", i), {30'd0, d4_resp1_valid, d4_resp0_valid}, 32'd0);
        end
        step();
        chk("d4_resp_valid", {30'd0, d4_resp1_valid, d4_resp0_valid}, 32'd1);
        chk("d4_result", d4_resp_result, 32'h40900000);
        d4_resp0_ready = 1'b1;
        step();
        d4_resp0_ready = 1'b0;

        // Reset two cycles into BUSY aborts the grant to requester 1
        d4_req0_valid = 1'b1;
        d4_req1_valid = 1'b1; d4_req1_a = 32'hC0400000; d4_req1_b = 32'h3FC00000;
        #1;
        chk("d4_rr_grant", {30'd0, d4_req1_ready, d4_req0_ready}, 32'd2);
        step();
        step();
        step();
        d4_rst_n = 1'b0;
        #1;
        chk("d4_rst_ready", {30'd0, d4_req1_ready, d4_req0_ready}, 32'd0);
        step();
        d4_rst_n = 1'b1;
        #1;
        chk("d4_abort_busy", {31'd0, d4_busy}, 32'd0);
        chk("d4_abort_mul_a", d4_mul_a, 32'd0);
        chk("d4_post_rst_grant", {30'd0, d4_req1_ready, d4_req0_ready}, 32'd1);
        d4_req0_valid = 1'b0; d4_req1_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("d4_no_resp%0d", i), {29'd0, d4_busy, d4_resp1_valid, d4_resp0_valid}, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
